// File: rtl/inst_fetch_unit_pkg.sv
// Types and constants shared by the fetch stage and the next-address unit.
package inst_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] NPC_OP_SEQ   = 2'd0;
  localparam logic [1:0] NPC_OP_PCREL = 2'd1;
  localparam logic [1:0] NPC_OP_JALR  = 2'd2;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Small synchronous FIFO with a clear input; pushing while full is allowed only alongside a pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == CW'(0));
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Next pointer/count/storage; clear wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC register, credit-limited in-order imem requests, response buffer, redirect flush.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] tag_count, buf_count;
  logic          tag_full, tag_empty, buf_full, buf_empty;
  logic [31:0]   tag_pc;
  fetch_pkt_t    buf_pkt, push_pkt;
  logic          credit_ok, accept, rsp_live, drop_now, buf_push, buf_pop;

  // Outstanding requests plus held entries must leave room for every response.
  assign credit_ok = !tag_full && !buf_full &&
                     (({1'b0, tag_count} + {1'b0, buf_count}) < (CW + 1)'(DEPTH));

  assign imem_req_valid = !rst && (state_q == ST_FETCH) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && !tag_empty;
  assign drop_now = rsp_live && (drop_cnt_q != CW'(0));
  assign buf_push = rsp_live && !drop_now && !redirect_valid;
  assign buf_pop  = !buf_empty && if_ready && !redirect_valid;
  assign push_pkt = '{pc: tag_pc, inst: imem_rsp_data};

  assign if_valid = !rst && !buf_empty;
  assign if_pc    = if_valid ? buf_pkt.pc : 32'h0000_0000;
  assign if_inst  = if_valid ? buf_pkt.inst : 32'h0000_0000;
  assign if_pc4   = if_pc + 32'd4;

  // Next-state, next-PC and drop-count logic; redirect takes priority over everything but reset.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      // Every response still in flight belongs to the old path; one arriving now is dropped here.
      drop_cnt_d = tag_count - CW'(rsp_live);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (drop_now) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= CW'(0);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .push      (accept),
    .push_data (fetch_pc_q),
    .pop       (rsp_live),
    .pop_data  (tag_pc),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_pkt_t))) u_buf_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_valid),
    .push      (buf_push),
    .push_data (push_pkt),
    .pop       (buf_pop),
    .pop_data  (buf_pkt),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit against a queue-based model of the fetch stream.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk, rst, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_rsp_valid, if_valid, if_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, if_pc, if_pc4, if_inst;

  inst_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .if_inst        (if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } mem_req_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_pkt_t;

  mem_req_t memq[$];
  exp_pkt_t outq[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rel_start = 0;
  int first_iv = -1;
  bit m_boot = 1'b1;
  logic [31:0] m_pc = RST_PC;

  bit d_rst = 1'b1, d_redir = 1'b0, d_req_ready = 1'b1, d_if_ready = 1'b1;
  logic [31:0] d_rpc = 32'h0;
  int lat_lo = 1, lat_hi = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit rsp, exp_rv, exp_iv, acc;
    mem_req_t e;
    @(negedge clk);
    rst            = d_rst;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    imem_req_ready = d_req_ready;
    if_ready       = d_if_ready;
    rsp = !d_rst && (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(memq[0].pc) : $urandom;
    #1;
    exp_rv = !d_rst && !m_boot && !d_redir && (memq.size() + outq.size() < DEPTH);
    exp_iv = !d_rst && (outq.size() > 0);
    check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    if (exp_rv) check_eq("req_addr", imem_req_addr, m_pc);
    check_eq("if_valid", {31'd0, if_valid}, {31'd0, exp_iv});
    if (exp_iv) begin
      check_eq("if_pc", if_pc, outq[0].pc);
      check_eq("if_pc4", if_pc4, outq[0].pc + 32'd4);
      check_eq("if_inst", if_inst, outq[0].inst);
    end else begin
      check_eq("if_pc_idle", if_pc, 32'h0);
      check_eq("if_inst_idle", if_inst, 32'h0);
    end
    if (if_valid && first_iv < 0) first_iv = cyc - rel_start;
    // Advance the model across the coming rising edge.
    if (d_rst) begin
      memq.delete();
      outq.delete();
      m_boot = 1'b1;
      m_pc   = RST_PC;
    end else begin
      acc = exp_rv && d_req_ready;
      if (exp_iv && d_if_ready && !d_redir) void'(outq.pop_front());
      if (rsp) begin
        e = memq.pop_front();
        if (!e.stale && !d_redir) outq.push_back('{e.pc, mem_word(e.pc)});
      end
      if (d_redir) begin
        outq.delete();
        foreach (memq[i]) memq[i].stale = 1'b1;
        m_pc = {d_rpc[31:2], 2'b00};
      end else if (acc) begin
        memq.push_back('{m_pc, cyc + $urandom_range(lat_hi, lat_lo), 1'b0});
        m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    bit found;
    bit [31:0] r;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; if_ready = 1'b1;

    // 1: reset, streaming with 1-cycle memory
    repeat (2) step();
    d_rst = 1'b0;
    rel_start = cyc;
    repeat (12) step();
    check_eq("first_if_valid_cycle", first_iv, 32'd3);

    // 2: decode stall
    d_if_ready = 1'b0;
    repeat (6) step();
    d_if_ready = 1'b1;
    repeat (8) step();

    // 3: memory stall at 0x8
    d_redir = 1'b1; d_rpc = 32'h8;
    step();
    d_redir = 1'b0; d_req_ready = 1'b0;
    repeat (3) step();
    d_req_ready = 1'b1;
    repeat (8) step();

    // 4: redirect with two outstanding
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (memq.size() == 2 && !memq[0].stale && !memq[1].stale) found = 1'b1;
      else step();
    end
    check_eq("t4_setup_reached", {31'd0, found}, 32'd1);
    lat_lo = 1; lat_hi = 1;
    d_redir = 1'b1; d_rpc = 32'h100;
    step();
    d_redir = 1'b0;
    repeat (10) step();

    // 5: redirect colliding with a live response and a pop
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && !memq[0].stale && outq.size() > 0) found = 1'b1;
      else step();
    end
    check_eq("t5_setup_reached", {31'd0, found}, 32'd1);
    d_redir = 1'b1; d_rpc = 32'h203;
    step();
    d_redir = 1'b0;
    repeat (10) step();

    // 6: reset with one outstanding and one buffered
    lat_lo = 2; lat_hi = 2; d_if_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (memq.size() == 1 && outq.size() == 1) found = 1'b1;
      else step();
    end
    check_eq("t6_setup_reached", {31'd0, found}, 32'd1);
    d_rst = 1'b1;
    step();
    d_rst = 1'b0; d_if_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    repeat (10) step();

    // address wrap at 2^32
    d_redir = 1'b1; d_rpc = 32'hFFFF_FFF9;
    step();
    d_redir = 1'b0;
    repeat (10) step();

    // randomized traffic
    lat_lo = 1; lat_hi = 3;
    for (int k = 0; k < 3000; k++) begin
      d_req_ready = ($urandom_range(99, 0) < 75);
      d_if_ready  = ($urandom_range(99, 0) < 70);
      d_redir     = ($urandom_range(99, 0) < 6);
      d_rst       = ($urandom_range(199, 0) == 0);
      r = $urandom;
      d_rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | (r & 32'h0000_000F)) : r;
      step();
    end
    d_redir = 1'b0; d_rst = 1'b0; d_req_ready = 1'b1; d_if_ready = 1'b1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
